aes_host_seq: RTL
=================

# aes_host_seq

Host-side sequencer that drives the 8-bit byte-serial pin interface of the AES core (`loadkey`, `load_shift`, `staenc`, `stadec`, `din`, `dout`) from a 128-bit parallel valid/ready interface. It serializes a key or data block into the core, issues the encrypt/decrypt start pulse, waits the core's fixed latency, and deserializes the 16 result bytes. The block sits in the FPGA test harness or SoC integration that talks to the padded AES chip.

## Interface
- `CORE_LAT`, 12, cycles from start-pulse cycle to first result byte; legal 1..31
- `clk`  in  1  single clock; all state rising-edge
- `rst`  in  1  asynchronous, active-low reset
- `key_vld`  in  1  key offer
- `key_in`  in  128  key, byte 15 (bits 127:120) sent first
- `key_rdy`  out  1  key accepted when `key_vld & key_rdy`
- `key_loaded`  out  1  a key has been loaded since reset
- `req_vld`  in  1  block request
- `req_dec`  in  1  1 = decrypt, 0 = encrypt
- `req_data`  in  128  input block, bits 127:120 first
- `req_rdy`  out  1  request accepted when `req_vld & req_rdy`
- `rsp_vld`  out  1  result valid
- `rsp_data`  out  128  result, first received byte in 127:120
- `rsp_rdy`  in  1  result consumed when `rsp_vld & rsp_rdy`
- `aes_loadkey`, `aes_load_shift`, `aes_staenc`, `aes_stadec`  out  1 each  core controls
- `aes_din`  out  8  byte to core
- `aes_dout`  in  8  byte from core

## Operation
- FSM states: IDLE, KEY, DIN, START, WAIT, DOUT, HOLD; 5-bit counter `cnt`; 128-bit shift register `sr`.
- IDLE: `key_rdy = 1`; `req_rdy = key_loaded`. Both offered same cycle -> key wins, request stays pending.
- KEY: 16 cycles, `aes_loadkey = 1`, `aes_din` = successive bytes MSB-first. Exit -> IDLE, `key_loaded <= 1`.
- DIN: 16 cycles, `aes_load_shift = 1`, bytes MSB-first; `req_dec` latched at accept.
- START: 1 cycle, `aes_stadec = 1` if latched dec else `aes_staenc = 1`; never both.
- WAIT: CORE_LAT cycles, all controls low.
- DOUT: 16 cycles, `aes_load_shift = 1`, `aes_din = 0`; each edge `sr <= {sr[119:0], aes_dout}`.
- HOLD: `rsp_vld = 1`, `rsp_data = sr` stable until `rsp_rdy`; then -> IDLE.
- `key_rdy`, `req_rdy` only in IDLE; no new key or request while a result is unconsumed.
- `key_vld` in non-IDLE states ignored (no accept).
- All `aes_*` outputs driven from flops (no combinational paths to pads).

## Timing
- Reset (`rst = 0`, any time, async): state IDLE, `cnt = 0`, `sr = 0`, `key_loaded = 0`, `rsp_vld = 0`, `key_rdy = 0` until first edge after release, all `aes_*` = 0. Mid-operation reset aborts; core must be rekeyed.
- Key: accept at edge T -> `aes_loadkey` high cycles T+1..T+16; `key_loaded` high from T+17; `key_rdy` high from T+17.
- Request: accept at edge T -> `aes_load_shift` high T+1..T+16; start pulse T+17; WAIT T+18..T+17+CORE_LAT; capture T+18+CORE_LAT..T+33+CORE_LAT; `rsp_vld` high from T+34+CORE_LAT (T+46 at default).
- `rsp_rdy` held high: IDLE one cycle after handshake; back-to-back request accepted that cycle; throughput one block per 35+CORE_LAT cycles.
- `cnt` counts 0..N-1 per state, reloads 0 on every transition; no wrap beyond 31.

## Structure
- Shared include `aes_io_defs.vh`: state encodings, `AES_NBYTES = 16`, `AES_BLK_W = 128`.
- One sub-module `aes_byte_shreg`: 128-bit shift register with parallel load, byte shift-out (top byte) and byte shift-in; used for `sr` in both directions.

## Test plan
- Key 000102..0f, then encrypt 00112233445566778899aabbccddeeff against behavioural core model -> `aes_din` 0x00..0x0f under loadkey, then 0x00,0x11..0xff under load_shift, one `aes_staenc` pulse, `rsp_data = 69c4e0d86a7b0430d8cdb78070b4c55a` at T+46.
- Decrypt 69c4e0d86a7b0430d8cdb78070b4c55a same key -> `aes_stadec` pulse only, `rsp_data = 00112233...eeff`.
- `req_vld` before any key -> `req_rdy = 0`, no `aes_*` activity; after key load request accepted.
- `key_vld` and `req_vld` same IDLE cycle -> key sequence first, request accepted at T+17.
- `rsp_rdy` low 20 cycles -> `rsp_vld`/`rsp_data` stable, `req_rdy = 0`; on release IDLE next cycle.
- Assert `rst` during DOUT byte 7 -> all outputs 0 immediately, `key_loaded = 0`, fresh key+block runs correctly.

Source files
------------

// File: rtl/aes_host_seq_pkg.sv
// Shared definitions for the AES host sequencer: block geometry, FSM
// state encodings and a small helper used when a block is first loaded.
package aes_host_seq_pkg;

  localparam int AES_NBYTES = 16;
  localparam int AES_BLK_W  = 128;
  localparam int CNT_W      = 5;

  // Last byte index of a 16-byte burst on the core pins.
  localparam logic [CNT_W-1:0] LAST_BYTE = 5'(AES_NBYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_KEY   = 3'd1,
    ST_DIN   = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DOUT  = 3'd5,
    ST_HOLD  = 3'd6
  } state_t;

  // The top byte goes straight to the pin register at accept time, so the
  // shift register only needs to hold the remaining 15 bytes.
  function automatic logic [AES_BLK_W-1:0] load_tail(input logic [AES_BLK_W-1:0] blk);
    return {blk[AES_BLK_W-9:0], 8'h00};
  endfunction

endpackage

// File: rtl/aes_host_seq_if.sv
// Parallel host-side interface of the AES sequencer: key offer, block
// request and result return, each with a valid/ready handshake.
interface aes_host_seq_if;
  import aes_host_seq_pkg::*;

  logic                 key_vld;
  logic [AES_BLK_W-1:0] key_in;
  logic                 key_rdy;
  logic                 key_loaded;
  logic                 req_vld;
  logic                 req_dec;
  logic [AES_BLK_W-1:0] req_data;
  logic                 req_rdy;
  logic                 rsp_vld;
  logic [AES_BLK_W-1:0] rsp_data;
  logic                 rsp_rdy;

  // Host side: offers keys and requests, consumes results.
  modport master (
    output key_vld, key_in, req_vld, req_dec, req_data, rsp_rdy,
    input  key_rdy, key_loaded, req_rdy, rsp_vld, rsp_data
  );

  // Sequencer side.
  modport slave (
    input  key_vld, key_in, req_vld, req_dec, req_data, rsp_rdy,
    output key_rdy, key_loaded, req_rdy, rsp_vld, rsp_data
  );

endinterface

// File: rtl/aes_byte_shreg.sv
// 128-bit shift register with parallel load. Shifts one byte per cycle
// towards the top: the top byte is the next byte out, the new byte enters
// at the bottom. Used both to serialize into and deserialize from the core.
module aes_byte_shreg
  import aes_host_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [AES_BLK_W-1:0] load_val,
  input  logic                 shift,
  input  logic [7:0]           shift_in,
  output logic [AES_BLK_W-1:0] q,
  output logic [7:0]           top_byte
);

  logic [AES_BLK_W-1:0] q_r;

  // Parallel load has priority over the byte shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_r <= {AES_BLK_W{1'b0}};
    end else if (load) begin
      q_r <= load_val;
    end else if (shift) begin
      q_r <= {q_r[AES_BLK_W-9:0], shift_in};
    end
  end

  assign q        = q_r;
  assign top_byte = q_r[AES_BLK_W-1 -: 8];

endmodule

// File: rtl/aes_host_seq.sv
// Host-side sequencer for the byte-serial AES core pins. Serializes keys
// and data blocks into the core, pulses encrypt/decrypt start, waits the
// fixed core latency, then collects the 16 result bytes and holds them
// until the host takes them. All core pin outputs come straight from flops.
module aes_host_seq
  import aes_host_seq_pkg::*;
#(
  parameter int CORE_LAT = 12
) (
  input  logic       clk,
  input  logic       rst,
  aes_host_seq_if.slave host,
  output logic       aes_loadkey,
  output logic       aes_load_shift,
  output logic       aes_staenc,
  output logic       aes_stadec,
  output logic [7:0] aes_din,
  input  logic [7:0] aes_dout
);

  localparam logic [CNT_W-1:0] WAIT_LAST = 5'(CORE_LAT - 1);

  state_t               state_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 dec_r;
  logic                 key_loaded_r;
  logic                 key_rdy_r;
  logic                 req_rdy_r;
  logic                 rsp_vld_r;

  logic                 key_acc_s;
  logic                 req_acc_s;
  logic                 sr_load_s;
  logic [AES_BLK_W-1:0] sr_load_val_s;
  logic                 sr_shift_s;
  logic [7:0]           sr_shift_in_s;
  logic [AES_BLK_W-1:0] sr_q_s;
  logic [7:0]           sr_top_s;

  // A key always wins over a request offered in the same cycle.
  assign key_acc_s = (state_r == ST_IDLE) && host.key_vld && key_rdy_r;
  assign req_acc_s = (state_r == ST_IDLE) && host.req_vld && req_rdy_r && !key_acc_s;

  // Shift-register control: load on accept, shift out during KEY/DIN,
  // shift the core output in during DOUT.
  always_comb begin
    sr_load_s     = 1'b0;
    sr_load_val_s = {AES_BLK_W{1'b0}};
    sr_shift_s    = 1'b0;
    sr_shift_in_s = 8'h00;
    case (state_r)
      ST_IDLE: begin
        if (key_acc_s) begin
          sr_load_s     = 1'b1;
          sr_load_val_s = load_tail(host.key_in);
        end else if (req_acc_s) begin
          sr_load_s     = 1'b1;
          sr_load_val_s = load_tail(host.req_data);
        end else begin
          sr_load_s     = 1'b0;
        end
      end
      ST_KEY, ST_DIN: sr_shift_s = 1'b1;
      ST_DOUT: begin
        sr_shift_s    = 1'b1;
        sr_shift_in_s = aes_dout;
      end
      default: sr_shift_s = 1'b0;
    endcase
  end

  aes_byte_shreg u_sr (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load_s),
    .load_val (sr_load_val_s),
    .shift    (sr_shift_s),
    .shift_in (sr_shift_in_s),
    .q        (sr_q_s),
    .top_byte (sr_top_s)
  );

  // Main sequencer FSM with registered handshake and core pin outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      cnt_r          <= 5'd0;
      dec_r          <= 1'b0;
      key_loaded_r   <= 1'b0;
      key_rdy_r      <= 1'b0;
      req_rdy_r      <= 1'b0;
      rsp_vld_r      <= 1'b0;
      aes_loadkey    <= 1'b0;
      aes_load_shift <= 1'b0;
      aes_staenc     <= 1'b0;
      aes_stadec     <= 1'b0;
      aes_din        <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 5'd0;
          if (key_acc_s) begin
            state_r     <= ST_KEY;
            key_rdy_r   <= 1'b0;
            req_rdy_r   <= 1'b0;
            aes_loadkey <= 1'b1;
            aes_din     <= host.key_in[AES_BLK_W-1 -: 8];
          end else if (req_acc_s) begin
            state_r        <= ST_DIN;
            dec_r          <= host.req_dec;
            key_rdy_r      <= 1'b0;
            req_rdy_r      <= 1'b0;
            aes_load_shift <= 1'b1;
            aes_din        <= host.req_data[AES_BLK_W-1 -: 8];
          end else begin
            key_rdy_r <= 1'b1;
            req_rdy_r <= key_loaded_r;
          end
        end
        ST_KEY: begin
          if (cnt_r == LAST_BYTE) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 5'd0;
            aes_loadkey  <= 1'b0;
            aes_din      <= 8'h00;
            key_loaded_r <= 1'b1;
            key_rdy_r    <= 1'b1;
            req_rdy_r    <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + 5'd1;
            aes_din <= sr_top_s;
          end
        end
        ST_DIN: begin
          if (cnt_r == LAST_BYTE) begin
            state_r        <= ST_START;
            cnt_r          <= 5'd0;
            aes_load_shift <= 1'b0;
            aes_din        <= 8'h00;
            aes_staenc     <= !dec_r;
            aes_stadec     <= dec_r;
          end else begin
            cnt_r   <= cnt_r + 5'd1;
            aes_din <= sr_top_s;
          end
        end
        ST_START: begin
          state_r    <= ST_WAIT;
          cnt_r      <= 5'd0;
          aes_staenc <= 1'b0;
          aes_stadec <= 1'b0;
        end
        ST_WAIT: begin
          if (cnt_r == WAIT_LAST) begin
            state_r        <= ST_DOUT;
            cnt_r          <= 5'd0;
            aes_load_shift <= 1'b1;
            aes_din        <= 8'h00;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        ST_DOUT: begin
          if (cnt_r == LAST_BYTE) begin
            state_r        <= ST_HOLD;
            cnt_r          <= 5'd0;
            aes_load_shift <= 1'b0;
            rsp_vld_r      <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 5'd1;
          end
        end
        ST_HOLD: begin
          if (host.rsp_rdy) begin
            state_r   <= ST_IDLE;
            rsp_vld_r <= 1'b0;
            key_rdy_r <= 1'b1;
            req_rdy_r <= key_loaded_r;
          end else begin
            rsp_vld_r <= 1'b1;
          end
        end
        default: begin
          state_r        <= ST_IDLE;
          cnt_r          <= 5'd0;
          key_rdy_r      <= 1'b0;
          req_rdy_r      <= 1'b0;
          rsp_vld_r      <= 1'b0;
          aes_loadkey    <= 1'b0;
          aes_load_shift <= 1'b0;
          aes_staenc     <= 1'b0;
          aes_stadec     <= 1'b0;
          aes_din        <= 8'h00;
        end
      endcase
    end
  end

  assign host.key_rdy    = key_rdy_r;
  assign host.key_loaded = key_loaded_r;
  assign host.req_rdy    = req_rdy_r;
  assign host.rsp_vld    = rsp_vld_r;
  assign host.rsp_data   = sr_q_s;

endmodule
